// File: rtl/mips_pkg.sv
// Shared MIPS pipeline constants, opcodes, and fetch FSM encoding.
// Also holds the helper that builds J-type jump targets.
package mips_pkg;

    localparam logic [31:0] NOP_WORD   = 32'h0000_0000;
    localparam logic [31:0] RESET_PC   = 32'h0000_0000;
    localparam int          IMEM_WORDS = 256;

    localparam logic [5:0] OP_J   = 6'b000010;
    localparam logic [5:0] OP_BEQ = 6'b000100;
    localparam logic [5:0] OP_BNE = 6'b000101;

    typedef enum logic [0:0] {
        ST_RUN   = 1'b0,
        ST_FAULT = 1'b1
    } fetch_state_t;

    // The jump target keeps the 256 MB region of the delay-slot PC.
    function automatic logic [31:0] jump_target(input logic [31:0] pc4,
                                                input logic [25:0] index);
        return {pc4[31:28], index, 2'b00};
    endfunction

endpackage

// File: rtl/pc_next_sel.sv
// Next-PC selector for the fetch stage.
// Redirects win over holds because they come from older instructions.
module pc_next_sel
    import mips_pkg::*;
(
    input  logic [31:0] pc,
    input  logic [31:0] pc_plus4,
    input  logic        branch_taken,
    input  logic [31:0] branch_target,
    input  logic        jump,
    input  logic [25:0] jump_index,
    input  logic [31:0] if_id_pc4,
    input  logic        stall,
    input  logic        hold_bad,
    output logic [31:0] pc_next
);

    // Priority mux: branch > jump > stall > bad-PC hold > sequential
    always_comb begin
        pc_next = pc_plus4;
        if (branch_taken) begin
            pc_next = branch_target;
        end else if (jump) begin
            pc_next = jump_target(if_id_pc4, jump_index);
        end else if (stall) begin
            pc_next = pc;
        end else if (hold_bad) begin
            pc_next = pc;
        end else begin
            pc_next = pc_plus4;
        end
    end

endmodule

// File: rtl/fetch_stage.sv
// Instruction-fetch stage: PC register, IF/ID pipeline register,
// RUN/FAULT bad-PC tracking and a count of valid fetches.
module fetch_stage
    import mips_pkg::*;
#(
    parameter logic [31:0] RESET_PC   = mips_pkg::RESET_PC,
    parameter int          IMEM_WORDS = mips_pkg::IMEM_WORDS,
    parameter logic [31:0] NOP_WORD   = mips_pkg::NOP_WORD
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stall,
    input  logic        flush,
    input  logic        branch_taken,
    input  logic [31:0] branch_target,
    input  logic        jump,
    input  logic [25:0] jump_index,
    output logic        imem_memread,
    output logic [31:0] imem_address,
    input  logic [31:0] imem_readdata,
    output logic [31:0] if_id_instr,
    output logic [31:0] if_id_pc4,
    output logic        if_id_valid,
    output logic        fault,
    output logic [31:0] fetch_count
);

    localparam logic [31:0] IMEM_WORDS_W = 32'(IMEM_WORDS);

    fetch_state_t state_r;
    fetch_state_t state_next_s;
    logic [31:0]  pc_r;
    logic [31:0]  pc_next_s;
    logic [31:0]  pc_plus4_s;
    logic [31:0]  word_idx_s;
    logic         pc_ok_s;
    logic         redirect_s;
    logic         in_fault_s;
    logic [31:0]  if_id_instr_r;
    logic [31:0]  if_id_pc4_r;
    logic         if_id_valid_r;
    logic [31:0]  fetch_count_r;

    assign pc_plus4_s = pc_r + 32'd4;
    assign word_idx_s = {2'b00, pc_r[31:2]};
    assign pc_ok_s    = (pc_r[1:0] == 2'b00) && (word_idx_s < IMEM_WORDS_W);
    assign redirect_s = branch_taken | jump;
    assign in_fault_s = (state_r == ST_FAULT);

    pc_next_sel u_pc_next_sel (
        .pc            (pc_r),
        .pc_plus4      (pc_plus4_s),
        .branch_taken  (branch_taken),
        .branch_target (branch_target),
        .jump          (jump),
        .jump_index    (jump_index),
        .if_id_pc4     (if_id_pc4_r),
        .stall         (stall),
        .hold_bad      (in_fault_s | ~pc_ok_s),
        .pc_next       (pc_next_s)
    );

    // FSM next state: a bad PC faults only when nothing else claims the cycle
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            ST_RUN: begin
                if (!pc_ok_s && !redirect_s && !stall) begin
                    state_next_s = ST_FAULT;
                end else begin
                    state_next_s = ST_RUN;
                end
            end
            ST_FAULT: begin
                if (redirect_s) begin
                    state_next_s = ST_RUN;
                end else begin
                    state_next_s = ST_FAULT;
                end
            end
            default: state_next_s = ST_RUN;
        endcase
    end

    // PC and FSM state registers
    always_ff @(posedge clk) begin
        if (rst) begin
            pc_r    <= RESET_PC;
            state_r <= ST_RUN;
        end else begin
            pc_r    <= pc_next_s;
            state_r <= state_next_s;
        end
    end

    // IF/ID register and fetch counter
    always_ff @(posedge clk) begin
        if (rst) begin
            if_id_instr_r <= NOP_WORD;
            if_id_pc4_r   <= 32'h0000_0000;
            if_id_valid_r <= 1'b0;
            fetch_count_r <= 32'd0;
        end else if (flush || redirect_s) begin
            if_id_instr_r <= NOP_WORD;
            if_id_pc4_r   <= 32'h0000_0000;
            if_id_valid_r <= 1'b0;
        end else if (stall) begin
            if_id_instr_r <= if_id_instr_r;
            if_id_pc4_r   <= if_id_pc4_r;
            if_id_valid_r <= if_id_valid_r;
        end else if (!in_fault_s && pc_ok_s) begin
            if_id_instr_r <= imem_readdata;
            if_id_pc4_r   <= pc_plus4_s;
            if_id_valid_r <= 1'b1;
            fetch_count_r <= fetch_count_r + 32'd1;
        end else begin
            if_id_instr_r <= NOP_WORD;
            if_id_pc4_r   <= 32'h0000_0000;
            if_id_valid_r <= 1'b0;
        end
    end

    assign imem_memread = (state_r == ST_RUN) & ~rst;
    assign imem_address = pc_r;
    assign if_id_instr  = if_id_instr_r;
    assign if_id_pc4    = if_id_pc4_r;
    assign if_id_valid  = if_id_valid_r;
    assign fault        = in_fault_s;
    assign fetch_count  = fetch_count_r;

endmodule

// File: doc/fetch_stage.md
Name: fetch_stage

Overview:
Instruction-fetch stage of the 5-stage MIPS pipeline, directly upstream of the instruction memory bank. Owns the PC register and drives the word-read request to the memory bank. Captures the returned word into the IF/ID pipeline register. Handles stall, flush, branch/jump redirect and bad-PC detection, and feeds the decode stage.

Parameters:
RESET_PC, 32'h0000_0000, PC value loaded on reset
IMEM_WORDS, 256, instruction memory depth in 32-bit words; word index >= this is out of range
NOP_WORD, 32'h0000_0000, bubble instruction written into IF/ID

Ports:
clk  in  1  system clock, all state on rising edge
rst  in  1  synchronous, active-high reset
stall  in  1  hazard unit: hold PC and IF/ID
flush  in  1  squash IF/ID contents (bubble) this cycle
branch_taken  in  1  branch resolved taken this cycle
branch_target  in  32  byte address of branch target
jump  in  1  J-type jump in ID this cycle
jump_index  in  26  instr[25:0] of the jump
imem_memread  out  1  read enable to instruction memory
imem_address  out  32  byte address to instruction memory (= PC)
imem_readdata  in  32  instruction word, combinational same cycle
if_id_instr  out  32  registered instruction to decode
if_id_pc4  out  32  registered PC+4 of that instruction
if_id_valid  out  1  IF/ID holds a real instruction
fault  out  1  in FAULT state (bad PC)
fetch_count  out  32  number of valid instructions loaded into IF/ID

Behaviour:
- Reset (rst=1 at edge): pc<=RESET_PC; if_id_instr<=NOP_WORD; if_id_pc4<=0; if_id_valid<=0; fault/state<=RUN; fetch_count<=0. rst overrides all other inputs.
- imem_memread = (state==RUN) & ~rst; imem_address = pc, driven combinationally from the register.
- pc_ok = (pc[1:0]==0) & ((pc>>2) < IMEM_WORDS).
- Jump target = {if_id_pc4[31:28], jump_index, 2'b00}.
- Next-PC priority: branch_taken > jump > stall (hold) > FAULT (hold) > pc+4.
  - Redirect beats stall because it comes from an older instruction.
  - pc+4 wraps modulo 2^32.
- IF/ID update priority:
  - flush, branch_taken or jump: load bubble (NOP_WORD, valid=0, pc4=0). Wrong-path squash.
  - else stall: hold all IF/ID fields.
  - else RUN & pc_ok: instr<=imem_readdata, pc4<=pc+4, valid<=1, fetch_count+=1 (wraps).
  - else (FAULT or !pc_ok): bubble.
- FSM states RUN, FAULT:
  - RUN -> FAULT: when !pc_ok and there is no redirect and no stall in that cycle. PC holds at the bad value; fault=1 from the next cycle.
  - FAULT -> RUN: on branch_taken or jump; the new PC is loaded the same edge.
  - FAULT with stall only: stays FAULT.
  - A redirect to another bad PC re-enters FAULT one cycle later.
- Latency: the instruction at PC p appears on if_id_instr one cycle after p is on imem_address, absent stall/flush.
- Simultaneous stall+flush: flush wins for IF/ID; PC holds.
- Reset mid-stall or mid-FAULT: normal reset values, no residue.

Decomposition:
- Shared package mips_pkg: NOP_WORD, RESET_PC, IMEM_WORDS, opcode constants (J=6'b000010, BEQ=6'b000100, BNE=6'b000101), FSM state encoding.
- One natural sub-module, pc_next_sel: combinational next-PC mux with priority and jump-target formation. The PC register, IF/ID register, FSM and counter stay in fetch_stage.

Test Plan:
- Reset then 4 free-running cycles with mem[0..3]=A,B,C,D:
  - addresses go 0,4,8,12;
  - IF/ID shows A..D with pc4 4,8,12,16 and valid=1;
  - fetch_count=4.
- Stall held 2 cycles while pc=8:
  - imem_address stays 8; IF/ID holds B/pc4=8;
  - on release, C loads; fetch_count does not advance during the stall.
- branch_taken=1, branch_target=0x20, with stall=1 at pc=12:
  - next pc=0x20; IF/ID becomes bubble (valid=0);
  - the following cycle loads mem[8] with pc4=0x24.
- jump with jump_index=26'h4 while if_id_pc4=0x1000_0010:
  - next pc=0x1000_0010 → FAULT (out of range) next cycle; fault=1, memread=0, bubbles;
  - then branch_taken to 0x0 → RUN, mem[0] fetched.
- Redirect to branch_target=0x6 (misaligned):
  - FAULT entered, pc held at 0x6, fault=1 held for 5 cycles with flush/stall toggling;
  - rst asserted mid-FAULT → pc=0, fault=0, valid=0.
- Same cycle flush=1, stall=1:
  - IF/ID becomes NOP_WORD/valid=0, pc unchanged, fetch_count unchanged.
